// File: rtl/xbus_mem_slave.sv
// rtl/xbus_mem_slave.sv - word-addressed split-transaction SRAM slave for one xbus
// Optional out-of-range checking is enabled by defining XBUS_MEM_SLAVE_RANGE_CHECK_EN.
module xbus_mem_slave #(
  parameter int    mem_size    = 1024,
  parameter int    wait_states = 0,
  parameter int    rd_latency  = 2,
  parameter string mem_init    = "NO",
  parameter string mem_data    = "data.hex"
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo,
  output logic        err_o
);
  localparam int         AW = $clog2(mem_size);
  localparam logic [3:0] WS = 4'(wait_states);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [31:0]     mem [mem_size];
  logic [AW-1:0]   idx;
  logic            accept;
  logic            rd_accept;
  logic            oor;
  logic            addr_unused;
  logic [31:0]     rd_word;
  logic [rd_latency-1:0] vld_q;
  logic [31:0]     dat_q [rd_latency];

  assign idx         = bus_addr_bi[AW+1:2];
  assign addr_unused = ^{bus_addr_bi[31:AW+2], bus_addr_bi[1:0]};

  // With no wait states the request is acknowledged in the cycle it appears.
  assign bus_ack_o = bus_req_i &&
                     ((wait_states == 0) ? (state_q == S_IDLE) : (state_q == S_ACK));
  assign accept    = bus_req_i && bus_ack_o;
  assign rd_accept = accept && !bus_we_i;

`ifdef XBUS_MEM_SLAVE_RANGE_CHECK_EN
  logic err_q;
  assign oor     = (bus_addr_bi[31:2] >= 30'(mem_size));
  assign rd_word = oor ? 32'hDEADBEEF : mem[idx];
  assign err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              err_q <= 1'b0;
    else if (accept && oor) err_q <= 1'b1;
  end
`else
  assign oor     = 1'b0;
  assign rd_word = mem[idx];
  assign err_o   = 1'b0;
`endif

  // WAIT covers the middle wait_states-1 cycles; ACK is the wait_states-th cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_req_i && wait_states != 0) begin
            if (WS == 4'd1) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WS - 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (!bus_req_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= S_ACK;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && bus_we_i && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_be_bi[b]) mem[idx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
      end
    end
  end

  // Data stages only advance with a valid token, so the last stage holds between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 0; k < rd_latency; k++) dat_q[k] <= 32'd0;
    end else begin
      vld_q[0] <= rd_accept;
      if (rd_accept) dat_q[0] <= rd_word;
      for (int k = 1; k < rd_latency; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign bus_resp_o   = vld_q[rd_latency-1];
  assign bus_rdata_bo = dat_q[rd_latency-1];
endmodule

// File: tb/tb_xbus_mem_slave.sv
// tb/tb_xbus_mem_slave.sv - bench for xbus_mem_slave (ws0/lat2, ws3/lat2, ws0/lat3 instances)
// Build with XBUS_MEM_SLAVE_RANGE_CHECK_EN defined to check the range-check feature.
module tb_xbus_mem_slave;
`ifdef XBUS_MEM_SLAVE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [2:0]  ack, resp, err;
  logic [31:0] rdata0, rdata1, rdata2;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  xbus_mem_slave #(.mem_size(1024), .wait_states(0), .rd_latency(2)) u0 (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
    .bus_be_bi(be), .bus_wdata_bi(wdata), .bus_ack_o(ack[0]), .bus_resp_o(resp[0]),
    .bus_rdata_bo(rdata0), .err_o(err[0]));
  xbus_mem_slave #(.mem_size(1024), .wait_states(3), .rd_latency(2)) u1 (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
    .bus_be_bi(be), .bus_wdata_bi(wdata), .bus_ack_o(ack[1]), .bus_resp_o(resp[1]),
    .bus_rdata_bo(rdata1), .err_o(err[1]));
  xbus_mem_slave #(.mem_size(1024), .wait_states(0), .rd_latency(3)) u2 (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
    .bus_be_bi(be), .bus_wdata_bi(wdata), .bus_ack_o(ack[2]), .bus_resp_o(resp[2]),
    .bus_rdata_bo(rdata2), .err_o(err[2]));

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (n) tick();
  endtask

  // Read on the ws=3 instance: ack in the 4th cycle of the held request, resp 2 edges later.
  task automatic ws3_read(input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 4'h0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("ws3_rd_ack", ack[1], c == 3);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    chk1("ws3_rd_resp_early", resp[1], 1'b0);
    tick();
    @(negedge clk);
    chk1("ws3_rd_resp", resp[1], 1'b1);
    chk32("ws3_rd_data", rdata1, exp);
    tick();
  endtask

  vec_t        tv [8];
  logic [31:0] mref [16];
  rsp_t        q [$];

  initial begin
    tv[0] = '{1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 32'h10, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
    tv[2] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
    tv[3] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'h12345678};
    tv[4] = '{1'b1, 1'b1, 32'h10, 4'h2, 32'h0000AB00, 1'b1, 1'b0, 32'h12345678};
    tv[5] = '{1'b1, 1'b0, 32'h12, 4'h0, 32'h0,        1'b1, 1'b0, 32'h12345678};
    tv[6] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b0, 32'h12345678};
    tv[7] = '{1'b0, 1'b0, 32'h0,  4'h0, 32'h0,        1'b0, 1'b1, 32'h1234AB78};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    chk32("rst_ack", {29'd0, ack}, 32'd0);
    chk32("rst_resp", {29'd0, resp}, 32'd0);
    chk32("rst_err", {29'd0, err}, 32'd0);
    chk32("rst_rdata0", rdata0, 32'd0);
    chk32("rst_rdata2", rdata2, 32'd0);
    tick();
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].req, tv[i].we, tv[i].addr, tv[i].be, tv[i].wdata);
      @(negedge clk);
      chk1($sformatf("tv%0d_ack", i), ack[0], tv[i].ack);
      chk1($sformatf("tv%0d_resp", i), resp[0], tv[i].resp);
      chk32($sformatf("tv%0d_rdata", i), rdata0, tv[i].rdata);
      chk1($sformatf("tv%0d_err", i), err[0], 1'b0);
      tick();
    end
    idle(2);

    // Held write on the ws=3 instance: exactly one ack, in the 4th cycle.
    drive(1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1("ws3_wr_ack", ack[1], c == 3);
      tick();
    end
    idle(3);
    ws3_read(32'h20, 32'hCAFEF00D);

    // Request dropped after one cycle: nothing accepted, FSM back in IDLE.
    drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h11111111);
    @(negedge clk);
    chk1("ws3_drop_ack0", ack[1], 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("ws3_drop_ack", ack[1], 1'b0);
      tick();
    end
    ws3_read(32'h20, 32'hCAFEF00D);
    idle(2);

    // Back-to-back reads on the lat=3 instance.
    for (int w = 0; w < 4; w++) begin
      drive(1'b1, 1'b1, 32'(w * 4), 4'hF, 32'hA0 + 32'(w));
      tick();
    end
    for (int r = 0; r < 9; r++) begin
      if (r < 4) drive(1'b1, 1'b0, 32'(r * 4), 4'h0, 32'd0);
      else       drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      @(negedge clk);
      if (r < 4) chk1("b2b_ack", ack[2], 1'b1);
      chk1($sformatf("b2b_resp%0d", r), resp[2], (r >= 3 && r <= 6));
      if (r >= 3 && r <= 6) chk32($sformatf("b2b_data%0d", r), rdata2, 32'hA0 + 32'(r - 3));
      tick();
    end

    // Read above the memory: DEADBEEF and sticky err with the check on, wrap to word 0 otherwise.
    drive(1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'd0);
    @(negedge clk);
    chk1("oor_ack", ack[0], 1'b1);
    chk1("oor_err_before", err[0], 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    chk1("oor_err_set", err[0], RC);
    tick();
    @(negedge clk);
    chk1("oor_resp", resp[0], 1'b1);
    chk32("oor_data", rdata0, RC ? 32'hDEADBEEF : 32'h000000A0);
    tick();
    idle(3);
    @(negedge clk);
    chk1("oor_err_sticky", err[0], RC);

    // Asynchronous reset with two reads in flight.
    tick();
    drive(1'b1, 1'b1, 32'h30, 4'hF, 32'h5A5A5A5A);
    tick();
    drive(1'b1, 1'b0, 32'h30, 4'h0, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h10, 4'h0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    chk1("rst_mid_resp_before", resp[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk32("rst_mid_resp_now", {29'd0, resp}, 32'd0);
    chk1("rst_mid_err", err[0], 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk32("rst_mid_no_resp", {29'd0, resp}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h30, 4'h0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    chk32("rst_mid_hold", rdata0, 32'd0);
    tick();
    @(negedge clk);
    chk1("rst_mid_rd_resp", resp[0], 1'b1);
    chk32("rst_mid_rd_data", rdata0, 32'h5A5A5A5A);
    tick();
    idle(2);

    // Random traffic on the ws=0/lat=2 instance against a word-array model.
    for (int w = 0; w < 16; w++) begin
      mref[w] = $urandom;
      drive(1'b1, 1'b1, 32'(w * 4), 4'hF, mref[w]);
      tick();
    end
    idle(1);
    begin
      logic        err_m = 1'b0;
      logic [31:0] last = 32'd0;
      bit          have_last = 1'b0;
      for (int t = 0; t < 303; t++) begin
        logic        r, w, o, exp_resp;
        int          word;
        logic [31:0] hi, a, d;
        logic [3:0]  b;
        r    = (t < 300) && ($urandom_range(0, 9) < 7);
        w    = 1'($urandom_range(0, 1));
        word = $urandom_range(0, 15);
        o    = ($urandom_range(0, 7) == 0);
        hi   = o ? 32'($urandom_range(1, 32'hFFFFF)) : 32'd0;
        a    = (hi << 12) | 32'(word * 4) | 32'($urandom_range(0, 3));
        b    = 4'($urandom_range(0, 15));
        d    = $urandom;
        drive(r, w, a, b, d);
        @(negedge clk);
        exp_resp = (q.size() > 0) && (q[0].due == t);
        chk1("rnd_ack", ack[0], r);
        chk1("rnd_resp", resp[0], exp_resp);
        if (exp_resp) begin
          last = q[0].data;
          have_last = 1'b1;
          void'(q.pop_front());
        end
        if (have_last) chk32("rnd_rdata", rdata0, last);
        chk1("rnd_err", err[0], err_m);
        if (r) begin
          if (RC && o) err_m = 1'b1;
          if (w && !(RC && o)) begin
            for (int k = 0; k < 4; k++)
              if (b[k]) mref[word][8*k +: 8] = d[8*k +: 8];
          end
          if (!w) q.push_back('{t + 2, (RC && o) ? 32'hDEADBEEF : mref[word]});
        end
        tick();
      end
      chk32("rnd_queue_empty", 32'(q.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
